// File: rtl/mem_load_ctrl_pkg.sv
// mem_load_ctrl_pkg: shared FSM states, funct3 load encodings and split detection for the load controller
package mem_load_ctrl_pkg;
  typedef enum logic [1:0] {S_IDLE, S_READ0, S_READ1, S_DONE} state_t;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  function automatic logic f3_valid(input logic [2:0] f3);
    return f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
  endfunction
  function automatic logic is_split(input logic [2:0] f3, input logic [1:0] off);
    return ((f3 == F3_LH || f3 == F3_LHU) && off == 2'd3) || (f3 == F3_LW && off != 2'd0);
  endfunction
endpackage

// File: rtl/mem_load_ctrl_load_extend.sv
// load_extend: sign/zero extension of a byte-shifted load word according to funct3
module load_extend
  import mem_load_ctrl_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);
  always_comb
    o_data = i_funct3 == F3_LB  ? {{24{i_word[7]}}, i_word[7:0]} :
             i_funct3 == F3_LH  ? {{16{i_word[15]}}, i_word[15:0]} :
             i_funct3 == F3_LBU ? {24'd0, i_word[7:0]} :
             i_funct3 == F3_LHU ? {16'd0, i_word[15:0]} : i_word;
endmodule

// File: rtl/mem_load_ctrl.sv
// mem_load_ctrl: load unit FSM with per-read timeout; split (misaligned) reads only with MEM_LOAD_MISALIGNED_EN
module mem_load_ctrl
  import mem_load_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic        iReq,
  input  logic [31:0] iAddr,
  input  logic [2:0]  iFunct3,
  output logic        oBusy,
  output logic        oDone,
  output logic [31:0] oData,
  output logic        oMisaligned,
  output logic        oBusErr,
  output logic        oMemRead,
  output logic [31:0] oMemAddr,
  input  logic        iMemReady,
  input  logic [31:0] iMemData
);
  state_t      r_state;
  logic [2:0]  r_f3;
  logic [1:0]  r_off;
  logic [7:0]  r_cnt;
  logic [31:0] r_lo;
  logic [31:0] r_mem_addr;
  logic [31:0] r_data;
  logic        r_mis;
  logic        r_err;
  logic [31:0] w_lo;
  logic [31:0] w_word;
  logic [31:0] w_ext;
  logic        w_timeout;
  // the final word is formatted in the same cycle the last beat arrives
  assign w_lo      = r_state == S_READ0 ? iMemData : r_lo;
  assign w_word    = 32'({iMemData, w_lo} >> {r_off, 3'b000});
  assign w_timeout = !iMemReady && r_cnt == 8'(TIMEOUT - 1);
  load_extend u_ext (.i_word(w_word), .i_funct3(r_f3), .o_data(w_ext));
  always_ff @(posedge iClock)
    if (iReset) begin
      r_state    <= S_IDLE;
      r_f3       <= '0;
      r_off      <= '0;
      r_cnt      <= '0;
      r_lo       <= '0;
      r_mem_addr <= '0;
      r_data     <= '0;
      r_mis      <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE:
          if (iReq) begin
            r_f3       <= iFunct3;
            r_off      <= iAddr[1:0];
            r_cnt      <= '0;
            r_mem_addr <= {iAddr[31:2], 2'b00};
            if (!f3_valid(iFunct3)) begin
              r_state <= S_DONE;
              r_data  <= '0;
              r_mis   <= 1'b0;
              r_err   <= 1'b0;
            end
`ifndef MEM_LOAD_MISALIGNED_EN
            else if (is_split(iFunct3, iAddr[1:0])) begin
              r_state <= S_DONE;
              r_data  <= '0;
              r_mis   <= 1'b1;
              r_err   <= 1'b0;
            end
`endif
            else r_state <= S_READ0;
          end
        S_READ0, S_READ1:
          if (iMemReady) begin
            r_lo <= iMemData;
`ifdef MEM_LOAD_MISALIGNED_EN
            if (r_state == S_READ0 && is_split(r_f3, r_off)) begin
              r_state    <= S_READ1;
              r_mem_addr <= r_mem_addr + 32'd4;
              r_cnt      <= '0;
            end else
`endif
            begin
              r_state <= S_DONE;
              r_data  <= w_ext;
              r_mis   <= 1'b0;
              r_err   <= 1'b0;
            end
          end else if (w_timeout) begin
            r_state <= S_DONE;
            r_data  <= '0;
            r_mis   <= 1'b0;
            r_err   <= 1'b1;
          end else r_cnt <= r_cnt + 8'd1;
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  assign oBusy       = r_state != S_IDLE;
  assign oDone       = r_state == S_DONE;
  assign oMemRead    = r_state == S_READ0 || r_state == S_READ1;
  assign oMemAddr    = r_mem_addr;
  assign oData       = r_data;
  assign oMisaligned = r_mis;
  assign oBusErr     = r_err;
endmodule
